// File: rtl/riscv_irq_pkg.sv
// rtl/riscv_irq_pkg.sv - shared IDs, pending-bit indices and FSM states for the interrupt receiver
package riscv_irq_pkg;

  localparam logic [4:0] IRQ_ID_TIMER = 5'd7;
  localparam logic [4:0] IRQ_ID_EXT   = 5'd11;
  localparam logic [4:0] IRQ_ID_DBG   = 5'd12;

  localparam int PEND_TMR = 0;
  localparam int PEND_EXT = 1;
  localparam int PEND_DBG = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_e;

  // One-hot pending mask for a cause ID; unknown IDs map to no bit.
  function automatic logic [2:0] id_to_mask(input logic [4:0] id);
    logic [2:0] m;
    m = 3'b000;
    case (id)
      IRQ_ID_TIMER: m[PEND_TMR] = 1'b1;
      IRQ_ID_EXT:   m[PEND_EXT] = 1'b1;
      IRQ_ID_DBG:   m[PEND_DBG] = 1'b1;
      default:      m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_irq_prio.sv
// rtl/riscv_irq_prio.sv - fixed-priority encoder: debug > external > timer
module riscv_irq_prio
  import riscv_irq_pkg::*;
(
  input  logic [2:0] eligible_i,
  output logic       any_o,
  output logic [4:0] id_o
);

  always_comb begin
    any_o = |eligible_i;
    id_o  = 5'd0;
    if (eligible_i[PEND_DBG]) begin
      id_o = IRQ_ID_DBG;
    end else if (eligible_i[PEND_EXT]) begin
      id_o = IRQ_ID_EXT;
    end else if (eligible_i[PEND_TMR]) begin
      id_o = IRQ_ID_TIMER;
    end
  end

endmodule

// File: rtl/riscv_irq_accept.sv
// rtl/riscv_irq_accept.sv - latches irq pulses, offers one trap at a time, acknowledges the serviced ID
// Optional request timeout and sticky timeout_o enabled by RISCV_IRQ_TIMEOUT_EN.
module riscv_irq_accept
  import riscv_irq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_i,
  input  logic [4:0] irq_id_i,
  output logic       irq_ack_o,
  output logic [4:0] irq_id_o,
  input  logic       mstatus_mie_i,
  input  logic       mie_mtie_i,
  input  logic       mie_meie_i,
  input  logic       debug_mode_i,
  input  logic [2:0] pend_clr_i,
  output logic [2:0] pending_o,
  output logic       trap_req_o,
  output logic [4:0] trap_id_o,
`ifdef RISCV_IRQ_TIMEOUT_EN
  output logic       timeout_o,
`endif
  input  logic       trap_accept_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_min
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  irq_state_e state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [4:0] trap_id_q, trap_id_d;
  logic [2:0] eligible;
  logic [2:0] set_mask;
  logic [2:0] ack_clr;
  logic       win_any;
  logic [4:0] win_id;
  logic       lat_eligible;

`ifdef RISCV_IRQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             timeout_q, timeout_d;
  logic             timeout_hit;
`endif

  assign eligible[PEND_DBG] = pend_q[PEND_DBG] & ~debug_mode_i;
  assign eligible[PEND_EXT] = pend_q[PEND_EXT] & mie_meie_i & mstatus_mie_i & ~debug_mode_i;
  assign eligible[PEND_TMR] = pend_q[PEND_TMR] & mie_mtie_i & mstatus_mie_i & ~debug_mode_i;

  riscv_irq_prio u_prio (
    .eligible_i (eligible),
    .any_o      (win_any),
    .id_o       (win_id)
  );

  // The offered cause stays valid only while its own bit is still eligible.
  assign lat_eligible = |(id_to_mask(trap_id_q) & eligible);
  assign set_mask     = irq_i ? id_to_mask(irq_id_i) : 3'b000;

  always_comb begin
    state_d   = state_q;
    trap_id_d = trap_id_q;
    ack_clr   = 3'b000;
`ifdef RISCV_IRQ_TIMEOUT_EN
    cnt_inc     = cnt_q + CNT_W'(1);
    cnt_d       = (state_q == REQ) ? cnt_inc : '0;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d   = REQ;
          trap_id_d = win_id;
        end
      end
      REQ: begin
        if (trap_accept_i) begin
          state_d = ACK;
          ack_clr = id_to_mask(trap_id_q);
        end else if (!lat_eligible) begin
          state_d = IDLE;
`ifdef RISCV_IRQ_TIMEOUT_EN
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
`endif
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new pulse in the same cycle as a clear keeps the bit set.
    pend_d = (pend_q & ~(pend_clr_i | ack_clr)) | set_mask;
`ifdef RISCV_IRQ_TIMEOUT_EN
    timeout_d = timeout_hit | (timeout_q & ~(|pend_clr_i));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 3'b000;
      trap_id_q <= 5'd0;
`ifdef RISCV_IRQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      trap_id_q <= trap_id_d;
`ifdef RISCV_IRQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign pending_o  = pend_q;
  assign trap_req_o = (state_q == REQ);
  assign trap_id_o  = trap_id_q;
  assign irq_ack_o  = (state_q == ACK);
  assign irq_id_o   = (state_q == ACK) ? trap_id_q : 5'd0;
`ifdef RISCV_IRQ_TIMEOUT_EN
  assign timeout_o  = timeout_q;
`endif

endmodule

// File: tb/tb_riscv_irq_accept.sv
// tb/tb_riscv_irq_accept.sv - scoreboard bench for riscv_irq_accept
module tb_riscv_irq_accept;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq_i;
  logic [4:0] irq_id_i;
  logic       irq_ack_o;
  logic [4:0] irq_id_o;
  logic       mstatus_mie_i, mie_mtie_i, mie_meie_i, debug_mode_i;
  logic [2:0] pend_clr_i;
  logic [2:0] pending_o;
  logic       trap_req_o;
  logic [4:0] trap_id_o;
  logic       trap_accept_i;
`ifdef RISCV_IRQ_TIMEOUT_EN
  logic       timeout_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_ack_q[$];

  always #5 clk = ~clk;

`ifdef RISCV_IRQ_TIMEOUT_EN
  riscv_irq_accept #(.TIMEOUT_CYCLES(4)) dut (
`else
  riscv_irq_accept dut (
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_i         (irq_i),
    .irq_id_i      (irq_id_i),
    .irq_ack_o     (irq_ack_o),
    .irq_id_o      (irq_id_o),
    .mstatus_mie_i (mstatus_mie_i),
    .mie_mtie_i    (mie_mtie_i),
    .mie_meie_i    (mie_meie_i),
    .debug_mode_i  (debug_mode_i),
    .pend_clr_i    (pend_clr_i),
    .pending_o     (pending_o),
    .trap_req_o    (trap_req_o),
    .trap_id_o     (trap_id_o),
`ifdef RISCV_IRQ_TIMEOUT_EN
    .timeout_o     (timeout_o),
`endif
    .trap_accept_i (trap_accept_i)
  );

  // Every acknowledge must match the oldest accepted ID; unexpected acks fail.
  always @(negedge clk) begin
    if (rst_n && irq_ack_o) begin
      n_cmp++;
      if (exp_ack_q.size() == 0) begin
        n_bad++;
        $display("FAIL ack_unexpected: irq_id_o=%0d, no ack expected", irq_id_o);
      end else begin
        logic [4:0] e;
        e = exp_ack_q.pop_front();
        if (irq_id_o !== e) begin
          n_bad++;
          $display("FAIL ack_id: got %0d expected %0d", irq_id_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] id);
    irq_i    = 1'b1;
    irq_id_i = id;
    step();
    irq_i    = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [4:0] exp_id);
    int n = 0;
    while (!trap_req_o && n < 8) begin
      step();
      n++;
    end
    n_cmp++;
    if (trap_req_o !== 1'b1 || trap_id_o !== exp_id) begin
      n_bad++;
      $display("FAIL %s: trap_req=%b id=%0d expected req=1 id=%0d", name, trap_req_o, trap_id_o, exp_id);
    end
  endtask

  task automatic accept_and_ack(input logic [4:0] id);
    trap_accept_i = 1'b1;
    exp_ack_q.push_back(id);
    step();
    trap_accept_i = 1'b0;
    n_cmp++;
    if (irq_ack_o !== 1'b1 || trap_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_cycle: ack=%b req=%b expected ack=1 req=0", irq_ack_o, trap_req_o);
    end
    step();
    n_cmp++;
    if (irq_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_one_cycle: ack=%b expected 0", irq_ack_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_i = 1'b0; irq_id_i = 5'd0; trap_accept_i = 1'b0;
    mstatus_mie_i = 1'b0; mie_mtie_i = 1'b0; mie_meie_i = 1'b0;
    debug_mode_i = 1'b0; pend_clr_i = 3'b000;
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({irq_ack_o, irq_id_o, pending_o, trap_req_o, trap_id_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state: ack=%b id=%0d pend=%b req=%b tid=%0d expected all 0",
               irq_ack_o, irq_id_o, pending_o, trap_req_o, trap_id_o);
    end
  endtask

  task automatic test_timer();
    mstatus_mie_i = 1'b1; mie_mtie_i = 1'b1; mie_meie_i = 1'b1;
    pulse(5'd7);
    n_cmp++;
    if (pending_o !== 3'b001 || trap_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timer_pend: pend=%b req=%b expected 001/0", pending_o, trap_req_o);
    end
    step();
    n_cmp++;
    if (trap_req_o !== 1'b1 || trap_id_o !== 5'd7) begin
      n_bad++;
      $display("FAIL timer_req_latency: req=%b id=%0d expected 1/7", trap_req_o, trap_id_o);
    end
    accept_and_ack(5'd7);
    n_cmp++;
    if (pending_o !== 3'b000) begin
      n_bad++;
      $display("FAIL timer_pend_clr: pend=%b expected 000", pending_o);
    end
  endtask

  task automatic test_unknown_and_idle_accept();
    pulse(5'd3);
    trap_accept_i = 1'b1;
    step();
    trap_accept_i = 1'b0;
    n_cmp++;
    if (pending_o !== 3'b000 || trap_req_o !== 1'b0 || irq_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL unknown_id: pend=%b req=%b ack=%b expected 000/0/0", pending_o, trap_req_o, irq_ack_o);
    end
  endtask

  task automatic test_priority();
    mstatus_mie_i = 1'b0;
    pulse(5'd7);
    pulse(5'd11);
    n_cmp++;
    if (pending_o !== 3'b011 || trap_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_pend: pend=%b req=%b expected 011/0", pending_o, trap_req_o);
    end
    mstatus_mie_i = 1'b1;
    wait_req("prio_first", 5'd11);
    accept_and_ack(5'd11);
    wait_req("prio_second", 5'd7);
    accept_and_ack(5'd7);
  endtask

  task automatic test_debug();
    mstatus_mie_i = 1'b0;
    pulse(5'd12);
    wait_req("debug_req", 5'd12);
    accept_and_ack(5'd12);
    debug_mode_i = 1'b1;
    pulse(5'd12);
    step(); step();
    n_cmp++;
    if (trap_req_o !== 1'b0 || pending_o[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL debug_mode_block: req=%b pend2=%b expected 0/1", trap_req_o, pending_o[2]);
    end
    pend_clr_i = 3'b100;
    step();
    pend_clr_i = 3'b000;
    debug_mode_i = 1'b0;
    n_cmp++;
    if (pending_o !== 3'b000) begin
      n_bad++;
      $display("FAIL sw_clear: pend=%b expected 000", pending_o);
    end
    mstatus_mie_i = 1'b1;
  endtask

  task automatic test_withdraw();
    pulse(5'd11);
    wait_req("withdraw_req", 5'd11);
    mie_meie_i = 1'b1;
    pulse(5'd12);
    n_cmp++;
    if (trap_id_o !== 5'd11 || trap_req_o !== 1'b1) begin
      n_bad++;
      $display("FAIL no_rearb: id=%0d req=%b expected 11/1", trap_id_o, trap_req_o);
    end
    pend_clr_i = 3'b100;
    mie_meie_i = 1'b0;
    step();
    pend_clr_i = 3'b000;
    n_cmp++;
    if (trap_req_o !== 1'b0 || pending_o[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL withdraw: req=%b pend1=%b expected 0/1", trap_req_o, pending_o[1]);
    end
    step();
    pend_clr_i = 3'b010;
    step();
    pend_clr_i = 3'b000;
    mie_meie_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    pulse(5'd7);
    wait_req("b2b_first", 5'd7);
    trap_accept_i = 1'b1;
    irq_i = 1'b1; irq_id_i = 5'd7;
    exp_ack_q.push_back(5'd7);
    step();
    trap_accept_i = 1'b0; irq_i = 1'b0;
    n_cmp++;
    if (irq_ack_o !== 1'b1 || pending_o !== 3'b001) begin
      n_bad++;
      $display("FAIL set_wins: ack=%b pend=%b expected 1/001", irq_ack_o, pending_o);
    end
    wait_req("b2b_second", 5'd7);
    accept_and_ack(5'd7);
  endtask

`ifdef RISCV_IRQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 1;
    pulse(5'd7);
    wait_req("to_req", 5'd7);
    step();
    while (trap_req_o && n < 10) begin
      n++;
      step();
    end
    n_cmp++;
    if (n !== 4 || timeout_o !== 1'b1 || pending_o[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout: req_cycles=%0d to=%b pend0=%b expected 4/1/1", n, timeout_o, pending_o[0]);
    end
    mstatus_mie_i = 1'b0;
    pend_clr_i = 3'b001;
    step();
    pend_clr_i = 3'b000;
    mstatus_mie_i = 1'b1;
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: to=%b expected 0", timeout_o);
    end
  endtask
`endif

  task automatic test_reset_mid_req();
    pulse(5'd11);
    wait_req("rst_req", 5'd11);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({irq_ack_o, irq_id_o, pending_o, trap_req_o, trap_id_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_req: ack=%b pend=%b req=%b tid=%0d expected all 0",
               irq_ack_o, pending_o, trap_req_o, trap_id_o);
    end
    step();
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (trap_req_o !== 1'b0 || exp_ack_q.size() != 0) begin
      n_bad++;
      $display("FAIL after_reset: req=%b pending_acks=%0d expected 0/0", trap_req_o, exp_ack_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_unknown_and_idle_accept();
    test_priority();
    test_debug();
    test_withdraw();
    test_back_to_back();
`ifdef RISCV_IRQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
